// File: rtl/morty_pkg.sv
// Shared constants and types for the Morty RV32I core writeback path.
package morty_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned REG_AW = 5;

  typedef enum logic {
    IDLE     = 1'b0,
    WAIT_MEM = 1'b1
  } wb_state_e;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

endpackage

// File: rtl/wb_stage_if.sv
// Execute/memory-to-writeback bus plus the register file write port.
interface wb_stage_if;
  import morty_pkg::*;

  logic              ex_valid;
  logic              ex_ready;
  logic [REG_AW-1:0] ex_rd;
  logic [XLEN-1:0]   ex_result;
  logic              ex_is_load;
  logic [2:0]        ex_funct3;
  logic [1:0]        ex_addr_lo;
  logic              mem_rvalid;
  logic [XLEN-1:0]   mem_rdata;
  logic              wb_we;
  logic [REG_AW-1:0] wb_rd;
  logic [XLEN-1:0]   wb_wdata;

  // Writeback stage side.
  modport slave (
    input  ex_valid, ex_rd, ex_result, ex_is_load, ex_funct3, ex_addr_lo,
    input  mem_rvalid, mem_rdata,
    output ex_ready, wb_we, wb_rd, wb_wdata
  );

  // Upstream / environment side.
  modport master (
    output ex_valid, ex_rd, ex_result, ex_is_load, ex_funct3, ex_addr_lo,
    output mem_rvalid, mem_rdata,
    input  ex_ready, wb_we, wb_rd, wb_wdata
  );

endinterface

// File: rtl/wb_stage_load_extract.sv
// Load data alignment and sign/zero extension; shared with the LSU.
module load_extract
  import morty_pkg::*;
(
  input  logic [XLEN-1:0] i_rdata,
  input  logic [2:0]      i_funct3,
  input  logic [1:0]      i_addr_lo,
  output logic [XLEN-1:0] o_data_c
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Select lane, then extend according to load type; unknown types act as LW.
  always_comb begin
    w_byte = i_rdata[7:0];
    case (i_addr_lo)
      2'd0:    w_byte = i_rdata[7:0];
      2'd1:    w_byte = i_rdata[15:8];
      2'd2:    w_byte = i_rdata[23:16];
      default: w_byte = i_rdata[31:24];
    endcase
    w_half = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];
    case (i_funct3)
      F3_LB:   o_data_c = {{(XLEN-8){w_byte[7]}}, w_byte};
      F3_LBU:  o_data_c = {{(XLEN-8){1'b0}}, w_byte};
      F3_LH:   o_data_c = {{(XLEN-16){w_half[15]}}, w_half};
      F3_LHU:  o_data_c = {{(XLEN-16){1'b0}}, w_half};
      default: o_data_c = i_rdata;
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// Morty writeback stage: retires ALU results and loads into the register file.
// Optional: define WB_INSTRET_EN to add a 64-bit retired-instruction counter.
module wb_stage
  import morty_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  wb_stage_if.slave     bus,
`ifdef WB_INSTRET_EN
  output logic [63:0]   instret,
`endif
  output logic          busy
);

  wb_state_e         r_state, w_state_nxt;
  logic              r_wb_we, w_wb_we_nxt;
  logic [REG_AW-1:0] r_wb_rd, w_wb_rd_nxt;
  logic [XLEN-1:0]   r_wb_wdata, w_wb_wdata_nxt;
  logic [REG_AW-1:0] r_p_rd, w_p_rd_nxt;
  logic [2:0]        r_p_funct3, w_p_funct3_nxt;
  logic [1:0]        r_p_addr_lo, w_p_addr_lo_nxt;
  logic              w_accept;
  logic              w_retire;
  logic [XLEN-1:0]   w_ext;

  load_extract u_load_extract (
    .i_rdata   (bus.mem_rdata),
    .i_funct3  (r_p_funct3),
    .i_addr_lo (r_p_addr_lo),
    .o_data_c  (w_ext)
  );

  assign bus.ex_ready = (r_state == IDLE);
  assign w_accept     = bus.ex_valid && (r_state == IDLE);

  // Next-state and next-output decode.
  always_comb begin
    w_state_nxt     = r_state;
    w_wb_we_nxt     = 1'b0;
    w_wb_rd_nxt     = r_wb_rd;
    w_wb_wdata_nxt  = r_wb_wdata;
    w_p_rd_nxt      = r_p_rd;
    w_p_funct3_nxt  = r_p_funct3;
    w_p_addr_lo_nxt = r_p_addr_lo;
    w_retire        = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          if (bus.ex_is_load) begin
            w_p_rd_nxt      = bus.ex_rd;
            w_p_funct3_nxt  = bus.ex_funct3;
            w_p_addr_lo_nxt = bus.ex_addr_lo;
            w_state_nxt     = WAIT_MEM;
          end else begin
            w_wb_rd_nxt    = bus.ex_rd;
            w_wb_wdata_nxt = bus.ex_result;
            w_wb_we_nxt    = (bus.ex_rd != '0);
            w_retire       = 1'b1;
          end
        end
      end
      WAIT_MEM: begin
        if (bus.mem_rvalid) begin
          w_wb_rd_nxt    = r_p_rd;
          w_wb_wdata_nxt = w_ext;
          w_wb_we_nxt    = (r_p_rd != '0);
          w_retire       = 1'b1;
          w_state_nxt    = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_wb_we     <= 1'b0;
      r_wb_rd     <= '0;
      r_wb_wdata  <= '0;
      r_p_rd      <= '0;
      r_p_funct3  <= '0;
      r_p_addr_lo <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_wb_we     <= w_wb_we_nxt;
      r_wb_rd     <= w_wb_rd_nxt;
      r_wb_wdata  <= w_wb_wdata_nxt;
      r_p_rd      <= w_p_rd_nxt;
      r_p_funct3  <= w_p_funct3_nxt;
      r_p_addr_lo <= w_p_addr_lo_nxt;
    end
  end

  assign bus.wb_we    = r_wb_we;
  assign bus.wb_rd    = r_wb_rd;
  assign bus.wb_wdata = r_wb_wdata;
  assign busy         = (r_state == WAIT_MEM);

`ifdef WB_INSTRET_EN
  logic [63:0] r_instret;

  // Count every retirement, x0 destinations included; wraps naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_instret <= '0;
    end else if (w_retire) begin
      r_instret <= r_instret + 64'(1);
    end
  end

  assign instret = r_instret;
`else
  logic w_unused_retire;
  assign w_unused_retire = w_retire;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Directed self-checking bench for wb_stage.
module tb_wb_stage;

  logic clk;
  logic rst_n;
  logic busy;
`ifdef WB_INSTRET_EN
  logic [63:0] instret;
  logic [63:0] exp_instret;
`endif

  int n_checks;
  int n_errors;
  logic [31:0] last_wdata;
  logic [4:0]  last_rd;

  wb_stage_if u_if ();

  wb_stage u_dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (u_if.slave),
`ifdef WB_INSTRET_EN
    .instret (instret),
`endif
    .busy    (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic note_retire();
`ifdef WB_INSTRET_EN
    exp_instret = exp_instret + 64'd1;
`endif
  endtask

  task automatic idle_inputs();
    u_if.ex_valid   = 1'b0;
    u_if.ex_rd      = '0;
    u_if.ex_result  = '0;
    u_if.ex_is_load = 1'b0;
    u_if.ex_funct3  = '0;
    u_if.ex_addr_lo = '0;
    u_if.mem_rvalid = 1'b0;
    u_if.mem_rdata  = '0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle_inputs();
    tick();
    tick();
    if (u_if.wb_we !== 1'b0) begin $display("FAIL reset_we got %b want 0", u_if.wb_we); n_errors++; end
    n_checks++;
    if (u_if.wb_rd !== 5'd0) begin $display("FAIL reset_rd got %0d want 0", u_if.wb_rd); n_errors++; end
    n_checks++;
    if (u_if.wb_wdata !== 32'h0) begin $display("FAIL reset_wdata got %h want 0", u_if.wb_wdata); n_errors++; end
    n_checks++;
    if (busy !== 1'b0) begin $display("FAIL reset_busy got %b want 0", busy); n_errors++; end
    n_checks++;
    if (u_if.ex_ready !== 1'b1) begin $display("FAIL reset_ready got %b want 1", u_if.ex_ready); n_errors++; end
    n_checks++;
`ifdef WB_INSTRET_EN
    if (instret !== 64'd0) begin $display("FAIL reset_instret got %0d want 0", instret); n_errors++; end
    n_checks++;
`endif
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_alu();
    u_if.ex_valid = 1'b1; u_if.ex_is_load = 1'b0;
    u_if.ex_rd = 5'd5; u_if.ex_result = 32'hDEADBEEF;
    tick();
    note_retire();
    u_if.ex_valid = 1'b0;
    if (u_if.wb_we !== 1'b1) begin $display("FAIL alu_we got %b want 1", u_if.wb_we); n_errors++; end
    n_checks++;
    if (u_if.wb_rd !== 5'd5) begin $display("FAIL alu_rd got %0d want 5", u_if.wb_rd); n_errors++; end
    n_checks++;
    if (u_if.wb_wdata !== 32'hDEADBEEF) begin $display("FAIL alu_wdata got %h want deadbeef", u_if.wb_wdata); n_errors++; end
    n_checks++;
    tick();
    if (u_if.wb_we !== 1'b0) begin $display("FAIL alu_we_pulse got %b want 0", u_if.wb_we); n_errors++; end
    n_checks++;
    if (u_if.wb_wdata !== 32'hDEADBEEF) begin $display("FAIL alu_wdata_hold got %h want deadbeef", u_if.wb_wdata); n_errors++; end
    n_checks++;
  endtask

  task automatic test_x0();
`ifdef WB_INSTRET_EN
    logic [63:0] before;
    before = instret;
`endif
    u_if.ex_valid = 1'b1; u_if.ex_is_load = 1'b0;
    u_if.ex_rd = 5'd0; u_if.ex_result = 32'h1234;
    tick();
    note_retire();
    u_if.ex_valid = 1'b0;
    if (u_if.wb_we !== 1'b0) begin $display("FAIL x0_we got %b want 0", u_if.wb_we); n_errors++; end
    n_checks++;
    if (u_if.wb_wdata !== 32'h1234) begin $display("FAIL x0_wdata got %h want 1234", u_if.wb_wdata); n_errors++; end
    n_checks++;
`ifdef WB_INSTRET_EN
    if (instret !== before + 64'd1) begin $display("FAIL x0_instret got %0d want %0d", instret, before + 64'd1); n_errors++; end
    n_checks++;
`endif
    tick();
    if (u_if.wb_we !== 1'b0) begin $display("FAIL x0_we_after got %b want 0", u_if.wb_we); n_errors++; end
    n_checks++;
  endtask

  task automatic test_load(input logic [2:0] f3, input logic [1:0] lo, input logic [31:0] exp, input string nm);
    u_if.ex_valid = 1'b1; u_if.ex_is_load = 1'b1; u_if.ex_rd = 5'd7;
    u_if.ex_funct3 = f3; u_if.ex_addr_lo = lo; u_if.ex_result = 32'h5555AAAA;
    tick();
    u_if.ex_valid = 1'b0; u_if.ex_is_load = 1'b0;
    if (u_if.wb_we !== 1'b0 || busy !== 1'b1 || u_if.ex_ready !== 1'b0) begin
      $display("FAIL %s_wait got we=%b busy=%b ready=%b want we=0 busy=1 ready=0", nm, u_if.wb_we, busy, u_if.ex_ready);
      n_errors++;
    end
    n_checks++;
    u_if.mem_rvalid = 1'b1; u_if.mem_rdata = 32'h80F17F81;
    tick();
    note_retire();
    u_if.mem_rvalid = 1'b0; u_if.mem_rdata = '0;
    if (u_if.wb_we !== 1'b1 || u_if.wb_rd !== 5'd7) begin
      $display("FAIL %s_write got we=%b rd=%0d want we=1 rd=7", nm, u_if.wb_we, u_if.wb_rd);
      n_errors++;
    end
    n_checks++;
    if (u_if.wb_wdata !== exp) begin $display("FAIL %s_data got %h want %h", nm, u_if.wb_wdata, exp); n_errors++; end
    n_checks++;
    if (u_if.ex_ready !== 1'b1 || busy !== 1'b0) begin
      $display("FAIL %s_ready got ready=%b busy=%b want 1 0", nm, u_if.ex_ready, busy);
      n_errors++;
    end
    n_checks++;
    tick();
    if (u_if.wb_we !== 1'b0) begin $display("FAIL %s_pulse got %b want 0", nm, u_if.wb_we); n_errors++; end
    n_checks++;
  endtask

  task automatic test_min_latency();
    // rvalid already high at accept must be ignored that cycle
    u_if.ex_valid = 1'b1; u_if.ex_is_load = 1'b1; u_if.ex_rd = 5'd3;
    u_if.ex_funct3 = 3'b010; u_if.ex_addr_lo = 2'd0;
    u_if.mem_rvalid = 1'b1; u_if.mem_rdata = 32'hCAFEF00D;
    tick();
    u_if.ex_valid = 1'b0; u_if.ex_is_load = 1'b0;
    if (u_if.wb_we !== 1'b0 || busy !== 1'b1) begin
      $display("FAIL minlat_first got we=%b busy=%b want 0 1", u_if.wb_we, busy);
      n_errors++;
    end
    n_checks++;
    tick();
    note_retire();
    u_if.mem_rvalid = 1'b0;
    if (u_if.wb_we !== 1'b1 || u_if.wb_rd !== 5'd3 || u_if.wb_wdata !== 32'hCAFEF00D) begin
      $display("FAIL minlat_write got we=%b rd=%0d data=%h want 1 3 cafef00d", u_if.wb_we, u_if.wb_rd, u_if.wb_wdata);
      n_errors++;
    end
    n_checks++;
    tick();
  endtask

  task automatic test_stall();
    u_if.ex_valid = 1'b1; u_if.ex_is_load = 1'b1; u_if.ex_rd = 5'd7;
    u_if.ex_funct3 = 3'b010; u_if.ex_addr_lo = 2'd0;
    tick();
    // Offer an ALU op throughout the stall; it must not be taken.
    u_if.ex_is_load = 1'b0; u_if.ex_rd = 5'd9; u_if.ex_result = 32'h99999999;
    for (int i = 0; i < 4; i++) begin
      if (u_if.ex_ready !== 1'b0 || busy !== 1'b1 || u_if.wb_we !== 1'b0) begin
        $display("FAIL stall_%0d got ready=%b busy=%b we=%b want 0 1 0", i, u_if.ex_ready, busy, u_if.wb_we);
        n_errors++;
      end
      n_checks++;
      tick();
    end
    u_if.ex_valid = 1'b0;
    u_if.mem_rvalid = 1'b1; u_if.mem_rdata = 32'h80F17F81;
    tick();
    note_retire();
    u_if.mem_rvalid = 1'b0;
    if (u_if.wb_we !== 1'b1 || u_if.wb_rd !== 5'd7 || u_if.wb_wdata !== 32'h80F17F81 || u_if.ex_ready !== 1'b1) begin
      $display("FAIL stall_write got we=%b rd=%0d data=%h ready=%b want 1 7 80f17f81 1",
               u_if.wb_we, u_if.wb_rd, u_if.wb_wdata, u_if.ex_ready);
      n_errors++;
    end
    n_checks++;
    tick();
    if (u_if.wb_we !== 1'b0 || u_if.wb_rd !== 5'd7) begin
      $display("FAIL stall_noalu got we=%b rd=%0d want 0 7", u_if.wb_we, u_if.wb_rd);
      n_errors++;
    end
    n_checks++;
  endtask

  task automatic test_spurious();
    last_wdata = u_if.wb_wdata;
    last_rd    = u_if.wb_rd;
    u_if.mem_rvalid = 1'b1; u_if.mem_rdata = 32'hFFFFFFFF;
    tick();
    tick();
    u_if.mem_rvalid = 1'b0;
    if (u_if.wb_we !== 1'b0 || busy !== 1'b0 || u_if.ex_ready !== 1'b1) begin
      $display("FAIL spurious_ctl got we=%b busy=%b ready=%b want 0 0 1", u_if.wb_we, busy, u_if.ex_ready);
      n_errors++;
    end
    n_checks++;
    if (u_if.wb_wdata !== 32'h80F17F81 || u_if.wb_rd !== 5'd7) begin
      $display("FAIL spurious_hold got data=%h rd=%0d want 80f17f81 7", u_if.wb_wdata, u_if.wb_rd);
      n_errors++;
    end
    n_checks++;
  endtask

  task automatic test_back_to_back();
    u_if.ex_valid = 1'b1; u_if.ex_is_load = 1'b0;
    u_if.ex_rd = 5'd1; u_if.ex_result = 32'h11111111;
    tick();
    note_retire();
    u_if.ex_rd = 5'd2; u_if.ex_result = 32'h22222222;
    if (u_if.wb_we !== 1'b1 || u_if.wb_rd !== 5'd1 || u_if.wb_wdata !== 32'h11111111) begin
      $display("FAIL b2b_first got we=%b rd=%0d data=%h want 1 1 11111111", u_if.wb_we, u_if.wb_rd, u_if.wb_wdata);
      n_errors++;
    end
    n_checks++;
    tick();
    note_retire();
    u_if.ex_valid = 1'b0;
    if (u_if.wb_we !== 1'b1 || u_if.wb_rd !== 5'd2 || u_if.wb_wdata !== 32'h22222222) begin
      $display("FAIL b2b_second got we=%b rd=%0d data=%h want 1 2 22222222", u_if.wb_we, u_if.wb_rd, u_if.wb_wdata);
      n_errors++;
    end
    n_checks++;
    tick();
  endtask

  task automatic test_reset_mid_load();
    u_if.ex_valid = 1'b1; u_if.ex_is_load = 1'b1; u_if.ex_rd = 5'd7;
    u_if.ex_funct3 = 3'b010; u_if.ex_addr_lo = 2'd0;
    tick();
    u_if.ex_valid = 1'b0; u_if.ex_is_load = 1'b0;
    if (busy !== 1'b1) begin $display("FAIL rstmid_busy_pre got %b want 1", busy); n_errors++; end
    n_checks++;
    #2;
    rst_n = 1'b0;
    #1;
    if (u_if.wb_we !== 1'b0 || busy !== 1'b0 || u_if.ex_ready !== 1'b1) begin
      $display("FAIL rstmid_async got we=%b busy=%b ready=%b want 0 0 1", u_if.wb_we, busy, u_if.ex_ready);
      n_errors++;
    end
    n_checks++;
    if (u_if.wb_rd !== 5'd0 || u_if.wb_wdata !== 32'h0) begin
      $display("FAIL rstmid_outs got rd=%0d data=%h want 0 0", u_if.wb_rd, u_if.wb_wdata);
      n_errors++;
    end
    n_checks++;
`ifdef WB_INSTRET_EN
    exp_instret = 64'd0;
`endif
    tick();
    rst_n = 1'b1;
    u_if.mem_rvalid = 1'b1; u_if.mem_rdata = 32'h12345678;
    tick();
    tick();
    u_if.mem_rvalid = 1'b0;
    if (u_if.wb_we !== 1'b0 || busy !== 1'b0 || u_if.wb_wdata !== 32'h0) begin
      $display("FAIL rstmid_late got we=%b busy=%b data=%h want 0 0 0", u_if.wb_we, busy, u_if.wb_wdata);
      n_errors++;
    end
    n_checks++;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
`ifdef WB_INSTRET_EN
    exp_instret = 64'd0;
`endif
    test_reset();
    test_alu();
    test_x0();
    test_load(3'b000, 2'd0, 32'hFFFFFF81, "lb");
    test_load(3'b100, 2'd3, 32'h00000080, "lbu");
    test_load(3'b001, 2'd2, 32'hFFFF80F1, "lh");
    test_load(3'b101, 2'd0, 32'h00007F81, "lhu");
    test_load(3'b010, 2'd0, 32'h80F17F81, "lw");
    test_load(3'b001, 2'd3, 32'hFFFF80F1, "lh_odd");
    test_load(3'b000, 2'd1, 32'h0000007F, "lb_lane1");
    test_load(3'b011, 2'd1, 32'h80F17F81, "f3_other");
    test_min_latency();
    test_stall();
    test_spurious();
    test_back_to_back();
`ifdef WB_INSTRET_EN
    if (instret !== exp_instret) begin $display("FAIL instret_total got %0d want %0d", instret, exp_instret); n_errors++; end
    n_checks++;
`endif
    test_reset_mid_load();
`ifdef WB_INSTRET_EN
    if (instret !== 64'd0) begin $display("FAIL instret_after_reset got %0d want 0", instret); n_errors++; end
    n_checks++;
`endif
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
